// File: rtl/win_line_buffer.sv
// Sliding KxK window generator over a raster pixel stream. Chained line memories
// feed one shift register per window row; frame-position flags ride with each window.
module win_line_buffer #(
   parameter int DATA_W   = 8,
   parameter int WIDTH    = 512,
   parameter int HEIGHT   = 512,
   parameter int R_KERNEL = 2
) (
   input  logic                                                   clk,
   input  logic                                                   rst_n,
   input  logic                                                   in_valid,
   input  logic                                                   in_sof,
   input  logic [DATA_W-1:0]                                      in_pixel,
   output logic [(2*R_KERNEL+1)*(2*R_KERNEL+1)*DATA_W-1:0]        win_out,
   output logic                                                   out_valid,
   output logic                                                   out_sof,
   output logic                                                   out_eof,
   output logic                                                   sync_err
);

   localparam int K     = 2*R_KERNEL + 1;
   localparam int N_LM  = 2*R_KERNEL;
   localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
   localparam logic [COL_W-1:0] COL_GATE = COL_W'(2*R_KERNEL);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
   localparam logic [ROW_W-1:0] ROW_GATE = ROW_W'(2*R_KERNEL);

   if (R_KERNEL < 1 || WIDTH <= 2*R_KERNEL || HEIGHT <= 2*R_KERNEL) begin : g_param_check
      $error("win_line_buffer: need R_KERNEL >= 1 and WIDTH, HEIGHT > 2*R_KERNEL");
   end

   logic [COL_W-1:0] col;
   logic [COL_W-1:0] eff_col;
   logic [COL_W-1:0] col_nxt;
   logic [ROW_W-1:0] row;
   logic [ROW_W-1:0] eff_row;
   logic [ROW_W-1:0] row_nxt;
   logic             at_origin;
   logic             win_gate;
   logic             is_first;
   logic             is_last;

   // A start-of-frame pixel is treated as position (0,0) regardless of the counters.
   always_comb begin
      eff_col   = in_sof ? '0 : col;
      eff_row   = in_sof ? '0 : row;
      at_origin = (col == '0) && (row == '0);
      col_nxt   = eff_col + COL_W'(1);
      row_nxt   = eff_row;
      if (eff_col == COL_LAST) begin
         col_nxt = '0;
         row_nxt = (eff_row == ROW_LAST) ? '0 : eff_row + ROW_W'(1);
      end
      win_gate = (eff_row >= ROW_GATE) && (eff_col >= COL_GATE);
      is_first = (eff_row == ROW_GATE) && (eff_col == COL_GATE);
      is_last  = (eff_row == ROW_LAST) && (eff_col == COL_LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col       <= '0;
         row       <= '0;
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         out_eof   <= 1'b0;
         sync_err  <= 1'b0;
      end else begin
         out_valid <= in_valid && win_gate;
         out_sof   <= in_valid && is_first;
         out_eof   <= in_valid && is_last;
         sync_err  <= in_valid && in_sof && !at_origin;
         if (in_valid) begin
            col <= col_nxt;
            row <= row_nxt;
         end
      end
   end

   // lm_rd[j] holds the pixel j+1 lines above the current position (read-before-write).
   logic [N_LM-1:0][DATA_W-1:0] lm_rd;
   logic [N_LM-1:0][DATA_W-1:0] lm_wr;

   for (genvar j = 0; j < N_LM; j++) begin : g_lm
      logic [DATA_W-1:0] mem [WIDTH];

      if (j == 0) begin : g_head
         assign lm_wr[j] = in_pixel;
      end else begin : g_chain
         assign lm_wr[j] = lm_rd[j-1];
      end

      assign lm_rd[j] = mem[eff_col];

      always_ff @(posedge clk) begin
         if (in_valid) begin
            mem[eff_col] <= lm_wr[j];
         end
      end
   end

   // Packed layout [row][col][bit] flattens to slice index row*K+col, matching win_out.
   logic [K-1:0][K-1:0][DATA_W-1:0] sr;
   logic [K-1:0][DATA_W-1:0]        feed;

   always_comb begin
      feed      = '0;
      feed[K-1] = in_pixel;
      for (int r = 0; r < K-1; r++) begin
         feed[r] = lm_rd[K-2-r];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr <= '0;
      end else if (in_valid) begin
         for (int r = 0; r < K; r++) begin
            sr[r] <= {feed[r], sr[r][K-1:1]};
         end
      end
   end

   assign win_out = sr;

endmodule

// File: tb/tb_win_line_buffer.sv
// Scoreboard bench for win_line_buffer at W=8, H=6, R=1 with pixel = row*16+col.
module tb_win_line_buffer;

   localparam int DW = 8;
   localparam int W  = 8;
   localparam int H  = 6;
   localparam int R  = 1;
   localparam int K  = 2*R + 1;
   localparam int WB = K*K*DW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_sof = 1'b0;
   logic [DW-1:0] in_pixel = '0;
   logic [WB-1:0] win_out;
   logic          out_valid;
   logic          out_sof;
   logic          out_eof;
   logic          sync_err;

   always #5 clk = ~clk;

   win_line_buffer #(
      .DATA_W  (DW),
      .WIDTH   (W),
      .HEIGHT  (H),
      .R_KERNEL(R)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_sof   (in_sof),
      .in_pixel (in_pixel),
      .win_out  (win_out),
      .out_valid(out_valid),
      .out_sof  (out_sof),
      .out_eof  (out_eof),
      .sync_err (sync_err)
   );

   typedef struct {
      logic [WB-1:0] win;
      logic          sof;
      logic          eof;
      int            cyc;
   } exp_t;

   exp_t q[$];
   int   cyc          = 0;
   int   n_tests      = 0;
   int   n_fail       = 0;
   int   exp_serr_cyc = -1;
   int   mr           = 0;
   int   mc           = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] pix(input int r, input int c);
      return DW'(r*16 + c);
   endfunction

   task automatic chk(input string name, input logic [WB-1:0] act, input logic [WB-1:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Drives one input cycle; for accepted pixels the model position decides the expectation.
   task automatic drive(input bit v, input bit s);
      exp_t e;
      @(negedge clk);
      if (v) begin
         if (s) begin
            if (mr != 0 || mc != 0) exp_serr_cyc = cyc + 1;
            mr = 0;
            mc = 0;
         end
         if (mr >= 2*R && mc >= 2*R) begin
            e.win = '0;
            for (int wr = 0; wr < K; wr++)
               for (int wc = 0; wc < K; wc++)
                  e.win[(wr*K+wc)*DW +: DW] = pix(mr-2*R+wr, mc-2*R+wc);
            e.sof = (mr == 2*R && mc == 2*R);
            e.eof = (mr == H-1 && mc == W-1);
            e.cyc = cyc + 1;
            q.push_back(e);
         end
         in_pixel = pix(mr, mc);
         if (mc == W-1) begin
            mc = 0;
            mr = (mr == H-1) ? 0 : mr + 1;
         end else begin
            mc++;
         end
      end else begin
         in_pixel = 8'hEE;
      end
      in_valid = v;
      in_sof   = v && s;
   endtask

   always begin
      exp_t e;
      @(posedge clk);
      #2;
      if (rst_n) begin
         if (out_valid) begin
            if (q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_window: got %h with no window expected (cycle %0d)", win_out, cyc);
            end else begin
               e = q.pop_front();
               chk("window", win_out, e.win);
               chk("out_sof", WB'(out_sof), WB'(e.sof));
               chk("out_eof", WB'(out_eof), WB'(e.eof));
               chk("lag_cycle", WB'(cyc), WB'(e.cyc));
            end
         end else begin
            chk("flags_idle", WB'({out_sof, out_eof}), '0);
            if (q.size() > 0 && q[0].cyc <= cyc) begin
               n_tests++;
               n_fail++;
               $display("FAIL missing_window: got out_valid=0 expected window %h (cycle %0d)", q[0].win, cyc);
               void'(q.pop_front());
            end
         end
         chk("sync_err", WB'(sync_err), WB'(cyc == exp_serr_cyc));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion expected finish before 100000 ns");
      $fatal(1, "timeout");
   end

   initial begin
      int sent;
      bit v;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_out_valid", WB'(out_valid), '0);
      chk("rst_win_out", win_out, '0);
      chk("rst_sync_err", WB'(sync_err), '0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_flags", WB'({out_valid, out_sof, out_eof, sync_err}), '0);

      // continuous frame, sof at origin is silent
      for (int i = 0; i < W*H; i++) drive(1'b1, i == 0);

      // same frame with gaps
      sent = 0;
      while (sent < W*H) begin
         v = 1'($urandom_range(0, 1));
         drive(v, 1'b0);
         if (v) sent++;
      end

      // two back-to-back frames each with sof on the first pixel
      for (int f = 0; f < 2; f++)
         for (int i = 0; i < W*H; i++) drive(1'b1, i == 0);

      // sof injected at (3,5) restarts the frame
      for (int i = 0; i < 3*W + 5; i++) drive(1'b1, 1'b0);
      drive(1'b1, 1'b1);
      for (int i = 1; i < W*H; i++) drive(1'b1, 1'b0);

      // async reset mid-line right after a valid window
      for (int i = 0; i < 3*W + 4; i++) drive(1'b1, 1'b0);
      @(posedge clk);
      #3;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("async_rst_out_valid", WB'(out_valid), '0);
      chk("async_rst_win_out", win_out, '0);
      chk("async_rst_flags", WB'({out_sof, out_eof, sync_err}), '0);
      q.delete();
      mr = 0;
      mc = 0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < W*H; i++) drive(1'b1, 1'b0);

      drive(1'b0, 1'b0);
      repeat (5) @(negedge clk);
      chk("queue_drained", WB'(q.size()), '0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/win_line_buffer.md
Name: win_line_buffer

Overview:
- Parametrised successor to the fixed 5x5 buffer feeding the Gaussian stage.
- Accepts a raster-order pixel stream with gaps allowed and a start-of-frame marker.
- Emits a fully-populated KxK window (K = 2*R_KERNEL+1) once per accepted pixel whose window lies wholly inside the frame. Border pixels are cropped.
- Outputs carry frame-position flags so downstream kernels (Gauss, Sobel, NMS) need no counters of their own.

Parameters:
- DATA_W, 8, pixel width in bits.
- WIDTH, 512, pixels per line.
- HEIGHT, 512, lines per frame.
- R_KERNEL, 2, window radius; K = 2*R_KERNEL+1.
- Legal range: R_KERNEL >= 1, WIDTH > 2*R_KERNEL, HEIGHT > 2*R_KERNEL. Violation triggers an elaboration-time error.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, in_pixel is valid this cycle.
- in_sof, input, 1, qualifies in_valid: this pixel is frame position (0,0).
- in_pixel, input, DATA_W, raster-order pixel.
- win_out, output, K*K*DATA_W, flattened window. Slice i = wr*K+wc occupies [i*DATA_W +: DATA_W]; wr=0 is the oldest line, wc=0 the oldest column.
- out_valid, output, 1, win_out is valid this cycle.
- out_sof, output, 1, first window of a frame (coincident with out_valid).
- out_eof, output, 1, last window of a frame (coincident with out_valid).
- sync_err, output, 1, one-cycle pulse when in_sof arrives with counters not at (0,0).

Behaviour:
- Storage:
  - 2*R_KERNEL line memories of WIDTH x DATA_W, chained.
  - K shift registers of K entries each, one per window row. Row K-1 is fed by in_pixel; rows 0..K-2 are fed by the line memories in age order.
- Counters: col (0..WIDTH-1) and row (0..HEIGHT-1) give the position of the pixel being accepted.
  - They advance only on in_valid.
  - col wraps to 0 and row increments after col = WIDTH-1.
  - After (HEIGHT-1, WIDTH-1) both wrap to 0 with no idle cycle required.
- Acceptance: when in_valid=0, all state holds and out_valid=0 next cycle.
- Output timing (registered, latency 1):
  - Accepting pixel (row, col) with row >= 2*R_KERNEL and col >= 2*R_KERNEL sets out_valid=1 on the next cycle.
  - win_out is then centred on (row-R_KERNEL, col-R_KERNEL). Slice K*K-1 equals that accepted pixel.
  - Otherwise out_valid=0.
- Output count: exactly (WIDTH-2R)*(HEIGHT-2R) valid windows per frame; 258064 at the defaults.
- Flags:
  - out_sof=1 with the window for accepted pixel (2R, 2R).
  - out_eof=1 with the window for (HEIGHT-1, WIDTH-1).
  - Both are 0 whenever out_valid=0.
- Column-wrap rule: windows never straddle lines. Invalid columns col < 2R are suppressed purely by the counter gate; no flushing is needed.
- in_sof handling:
  - An accepted pixel with in_sof=1 is forced to position (0,0). Counters reload to col=1, row=0 (or row=1 when WIDTH=1, which is impossible by the parameter constraints).
  - If the counters were not already (0,0), sync_err pulses one cycle later.
  - No window from the aborted frame is emitted after the in_sof pixel.
  - in_sof while counters are (0,0) is silent.
- Stale data: line memories are never cleared. Stale contents are never exposed because the row gate holds out_valid low until 2R fresh lines exist.
- Reset (async assert, sync-safe deassert):
  - col=0, row=0.
  - out_valid=0, out_sof=0, out_eof=0, sync_err=0.
  - win_out resets to 0.
  - Reset mid-frame discards the partial frame; the next accepted pixel is (0,0).
- No backpressure: the consumer must accept every out_valid cycle.

Test Plan:
- W=8, H=6, R=1, continuous in_valid, pixel value = row*16+col -> 24 out_valid cycles.
  - First window: out_sof=1, win_out slices = {00,01,02,10,11,12,20,21,22}.
  - Last window: out_eof=1, centre = 0x46.
  - Each window lags its accepted pixel by exactly 1 cycle.
- Same frame with in_valid toggled 1/0 pseudo-randomly -> identical window sequence and count. out_valid is never asserted in the cycle after a gap.
- Two back-to-back frames, second with in_sof on its first pixel -> 24+24 windows, no sync_err. Second out_sof follows first out_eof by the expected accepted-pixel count (2*W+2R+1 = 19).
- in_sof injected at (3,5) of the first frame -> sync_err pulse next cycle. Next 2R lines give out_valid=0, then a clean 24-window frame.
- rst_n dropped asynchronously mid-line -> outputs 0 immediately. After release, a full frame produces 24 correct windows.
- Defaults (512x512, R=2) with the gray image stream -> 258064 windows. Output matches the fixed-5x5 buffer + gauss_filter result byte-for-byte.
